// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman length-framed word format (packer and analyzer).
package huff_pkg;

  // END marker placed directly above the last payload bit.
  localparam logic [5:0] HUFF_END = 6'b010010;

  localparam int unsigned HUFF_BUS_WIDTH = 64;
  localparam int unsigned HUFF_CAP       = HUFF_BUS_WIDTH - 6;
  localparam int unsigned HUFF_FILL_W    = $clog2(HUFF_BUS_WIDTH - 5);

  typedef enum logic [0:0] {
    StAccum,
    StEmit
  } huff_pack_st_e;

  // Width needed to hold a fill count of 0..bus_width-6.
  function automatic int unsigned huff_fill_w(int unsigned bus_width);
    return $clog2(bus_width - 5);
  endfunction

endpackage

// File: rtl/huff_word_fmt.sv
// Formats an accumulated payload into {zeros, END_, payload}.
module huff_word_fmt
  import huff_pkg::*;
#(
  parameter logic [5:0]  END_      = HUFF_END,
  parameter int unsigned BUS_WIDTH = HUFF_BUS_WIDTH,
  localparam int unsigned CAP      = BUS_WIDTH - 6,
  localparam int unsigned FW       = huff_fill_w(BUS_WIDTH)
) (
  input  logic [CAP-1:0]       acc,
  input  logic [FW-1:0]        fill,
  output logic [BUS_WIDTH-1:0] word
);

  logic [CAP-1:0]       payload;
  logic [BUS_WIDTH-1:0] marker;

  always_comb begin
    // Masking keeps the word clean even if stale bits sit above fill.
    payload = acc & ~({CAP{1'b1}} << fill);
    marker  = {{(BUS_WIDTH - 6){1'b0}}, END_} << fill;
    word    = marker | {6'b000000, payload};
  end

endmodule

// File: rtl/huff_len_pack.sv
// Packs variable-length Huffman codes LSB-first into END-marked bus words.
// Optional illegal-length drop and sticky len_err under HUFF_PACK_LEN_CHECK_EN.
module huff_len_pack
  import huff_pkg::*;
#(
  parameter logic [5:0]  END_       = HUFF_END,
  parameter int unsigned BUS_WIDTH  = HUFF_BUS_WIDTH,
  parameter int unsigned CODE_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CODE_WIDTH-1:0]          code_in,
  input  logic [LEN_WIDTH-1:0]           code_len,
  input  logic                           code_valid,
  output logic                           code_ready,
  input  logic                           flush,
  output logic [BUS_WIDTH-1:0]           dout,
  output logic [$clog2(BUS_WIDTH-5)-1:0] dout_len,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic                           len_err
);

  localparam int unsigned CAP = BUS_WIDTH - 6;
  localparam int unsigned FW  = huff_fill_w(BUS_WIDTH);
  localparam int unsigned SW  = ((FW > LEN_WIDTH) ? FW : LEN_WIDTH) + 1;

  huff_pack_st_e        state_q, state_d;
  logic [CAP-1:0]       acc_q, acc_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [BUS_WIDTH-1:0] dout_q;
  logic [FW-1:0]        dout_len_q;

  logic [SW-1:0]        sum;
  logic                 fits;
  logic                 len_ok;
  logic                 take;
  logic [BUS_WIDTH-1:0] code_ext;
  logic [BUS_WIDTH-1:0] code_sh;
  logic [BUS_WIDTH-1:0] word;
  logic                 unused_code_sh_hi;

`ifdef HUFF_PACK_LEN_CHECK_EN
  logic len_err_q;

  assign len_ok = (code_len != '0) && (SW'(code_len) <= SW'(CODE_WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      len_err_q <= 1'b0;
    end else if (state_q == StAccum && code_valid && !len_ok) begin
      len_err_q <= 1'b1;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_ok  = 1'b1;
  assign len_err = 1'b0;
`endif

  assign code_ext          = {{(BUS_WIDTH - CODE_WIDTH){1'b0}}, code_in};
  assign unused_code_sh_hi = ^code_sh[BUS_WIDTH-1:CAP];

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    fill_d     = fill_q;
    code_ready = 1'b0;
    take       = 1'b0;
    // One bit wider than fill so fill+code_len cannot wrap.
    sum        = SW'(fill_q) + SW'(code_len);
    fits       = (sum <= SW'(CAP));
    code_sh    = (code_ext & ~({BUS_WIDTH{1'b1}} << code_len)) << fill_q;

    unique case (state_q)
      StAccum: begin
        // Illegal lengths (check build only) are accepted and dropped.
        code_ready = fits || !len_ok;
        take       = code_valid && len_ok && fits;
        if (take) begin
          acc_d  = acc_q | code_sh[CAP-1:0];
          fill_d = sum[FW-1:0];
        end
        if (take && (sum == SW'(CAP))) begin
          state_d = StEmit;
        end else if (code_valid && len_ok && !fits) begin
          // Overflowing code stays pending for the next word.
          state_d = StEmit;
        end else if (flush && (fill_d != '0)) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (dout_ready) begin
          acc_d   = '0;
          fill_d  = '0;
          state_d = StAccum;
        end
      end
      default: begin
        state_d = StAccum;
      end
    endcase
  end

  huff_word_fmt #(
    .END_      (END_),
    .BUS_WIDTH (BUS_WIDTH)
  ) u_fmt (
    .acc  (acc_d),
    .fill (fill_d),
    .word (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StAccum;
      acc_q      <= '0;
      fill_q     <= '0;
      dout_q     <= '0;
      dout_len_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      if (state_q == StAccum && state_d == StEmit) begin
        dout_q     <= word;
        dout_len_q <= fill_d;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_len   = dout_len_q;
  assign dout_valid = (state_q == StEmit);

endmodule
